// File: rtl/gray_pkg.sv
// gray_pkg: shared width limit, conversion-mode enum and binary/Gray helpers
package gray_pkg;
  localparam int GRAY_MAX_W = 32;
  typedef enum logic {CONV_B2G = 1'b0, CONV_G2B = 1'b1} conv_mode_e;
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_conv_stage.sv
// gray_conv_stage: one-cycle registered bin<->Gray converter; conv_in/conv_mode/conv_in_valid in, conv_out/conv_out_valid out
module gray_conv_stage
  import gray_pkg::*;
#(
  parameter int width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conv_in_valid,
  input  logic             conv_mode,
  input  logic [width-1:0] conv_in,
  output logic             conv_out_valid,
  output logic [width-1:0] conv_out
);
  logic [width-1:0] out_q, out_d;
  logic             valid_q;
  always_comb begin
    out_d = !conv_in_valid ? out_q :
            conv_mode_e'(conv_mode) == CONV_G2B ? width'(gray2bin(GRAY_MAX_W'(conv_in))) :
            width'(bin2gray(GRAY_MAX_W'(conv_in)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= conv_in_valid;
    end
  end
  assign conv_out       = out_q;
  assign conv_out_valid = valid_q;
endmodule

// File: rtl/gray_seq_converter.sv
// gray_seq_converter: up/down/loadable Gray counter (bin, grey, wrap out; en, up, load, load_bin in) plus independent registered conversion path
module gray_seq_converter
  import gray_pkg::*;
#(
  parameter int width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [width-1:0] load_bin,
  output logic [width-1:0] bin,
  output logic [width-1:0] grey,
  output logic             wrap,
  input  logic             conv_in_valid,
  input  logic             conv_mode,
  input  logic [width-1:0] conv_in,
  output logic             conv_out_valid,
  output logic [width-1:0] conv_out
);
  logic [width-1:0] bin_q, bin_d, grey_q, grey_d;
  logic             wrap_q, wrap_d;
  always_comb begin
    bin_d  = load ? load_bin : en ? (up ? bin_q + width'(1) : bin_q - width'(1)) : bin_q;
    wrap_d = !load && en && (up ? &bin_q : ~|bin_q);
    grey_d = width'(bin2gray(GRAY_MAX_W'(bin_d)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      grey_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      grey_q <= grey_d;
      wrap_q <= wrap_d;
    end
  end
  assign bin  = bin_q;
  assign grey = grey_q;
  assign wrap = wrap_q;
  gray_conv_stage #(.width(width)) u_conv (
    .clk           (clk),
    .rst           (rst),
    .conv_in_valid (conv_in_valid),
    .conv_mode     (conv_mode),
    .conv_in       (conv_in),
    .conv_out_valid(conv_out_valid),
    .conv_out      (conv_out)
  );
endmodule

// File: tb/tb_gray_seq_converter.sv
// tb_gray_seq_converter: drives width-3 and width-8 instances with shared stimulus and checks both against a behavioural model
module tb_gray_seq_converter;
  logic clk = 0, rst = 1, en = 0, up = 0, load = 0, cv = 0, cm = 0;
  logic [7:0] lb = 0, ci = 0;
  logic [2:0] bin3, grey3, co3;
  logic [7:0] bin8, grey8, co8;
  logic wrap3, wrap8, cov3, cov8;
  int n_cmp = 0, n_bad = 0;
  int unsigned mb[2], mg[2], mw[2], mco[2];
  int unsigned msk[2] = '{32'h7, 32'hFF};
  bit mcov = 0, mcnt = 0;
  logic [7:0] pg3, pg8;
  always #5 clk = ~clk;
  gray_seq_converter #(.width(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb[2:0]),
    .bin(bin3), .grey(grey3), .wrap(wrap3),
    .conv_in_valid(cv), .conv_mode(cm), .conv_in(ci[2:0]),
    .conv_out_valid(cov3), .conv_out(co3)
  );
  gray_seq_converter #(.width(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb),
    .bin(bin8), .grey(grey8), .wrap(wrap8),
    .conv_in_valid(cv), .conv_mode(cm), .conv_in(ci),
    .conv_out_valid(cov8), .conv_out(co8)
  );
  function automatic int unsigned g2b(int unsigned g);
    int unsigned b = 0;
    for (int s = 0; s < 32; s++) b ^= g >> s;
    return b;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mb[k] = 0; mw[k] = 0; mco[k] = 0;
      end else begin
        mw[k] = 0;
        if (load) mb[k] = lb & msk[k];
        else if (en) begin
          mw[k] = up ? int'(mb[k] == msk[k]) : int'(mb[k] == 0);
          mb[k] = (up ? mb[k] + 1 : mb[k] - 1) & msk[k];
        end
        if (cv) mco[k] = cm ? g2b(ci & msk[k]) : ((ci & msk[k]) ^ ((ci & msk[k]) >> 1));
      end
      mg[k] = mb[k] ^ (mb[k] >> 1);
    end
    mcov = !rst && cv;
    mcnt = !rst && !load && en;
  end
  always @(negedge clk) begin
    chk("bin3", bin3, mb[0]);   chk("grey3", grey3, mg[0]); chk("wrap3", wrap3, mw[0]);
    chk("conv3", co3, mco[0]);  chk("cvld3", cov3, mcov);
    chk("bin8", bin8, mb[1]);   chk("grey8", grey8, mg[1]); chk("wrap8", wrap8, mw[1]);
    chk("conv8", co8, mco[1]);  chk("cvld8", cov8, mcov);
    if (mcnt) begin
      chk("onebit3", $countones(grey3 ^ pg3), 1);
      chk("onebit8", $countones(grey8 ^ pg8), 1);
    end
    pg3 = grey3;
    pg8 = grey8;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [2:0] tbl[9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    tick(); tick();
    chk("rst_bin", bin3, 0); chk("rst_grey", grey3, 0); chk("rst_wrap", wrap3, 0);
    chk("rst_co", co3, 0); chk("rst_cov", cov3, 0);
    rst = 0; en = 1; up = 1;
    for (int i = 1; i < 9; i++) begin
      tick();
      chk("seq_grey", grey3, tbl[i]);
      chk("seq_wrap", wrap3, i == 8);
    end
    en = 0; load = 1; lb = 8'h05;
    tick(); chk("ld_bin", bin3, 3'b101); chk("ld_grey", grey3, 3'b111); chk("ld_wrap", wrap3, 0);
    en = 1; lb = 8'h02;
    tick(); chk("lden_bin", bin3, 3'b010); chk("lden_grey", grey3, 3'b011);
    lb = 8'h00;
    tick();
    load = 0; up = 0;
    tick(); chk("dn_bin", bin3, 3'b111); chk("dn_grey", grey3, 3'b100); chk("dn_wrap", wrap3, 1);
    tick(); chk("dn2_bin", bin3, 3'b110); chk("dn2_grey", grey3, 3'b101); chk("dn2_wrap", wrap3, 0);
    for (int i = 0; i < 12; i++) begin
      up = 1'($urandom_range(0, 1));
      tick();
    end
    en = 0; cv = 1; cm = 0; ci = 8'h06;
    tick(); chk("cv_b2g", co3, 3'b101); chk("cv_vld", cov3, 1);
    cm = 1;
    tick(); chk("cv_g2b_a", co3, 3'b100);
    ci = 8'h04;
    tick(); chk("cv_g2b_b", co3, 3'b111);
    cv = 0;
    tick(); chk("cv_hold", co3, 3'b111); chk("cv_novld", cov3, 0);
    load = 1; lb = 8'h03;
    tick();
    load = 0; en = 1; up = 1; cv = 1; cm = 0; ci = 8'h05; rst = 1;
    tick();
    chk("mr_bin", bin3, 0); chk("mr_grey", grey3, 0); chk("mr_wrap", wrap3, 0);
    chk("mr_co", co3, 0); chk("mr_cov", cov3, 0);
    rst = 0; cv = 0;
    tick(); chk("mr_resume", bin3, 3'b001);
    en = 0; load = 1; lb = 8'hFE;
    tick();
    load = 0; en = 1; up = 1;
    tick(); chk("w8_bin1", bin8, 8'hFF); chk("w8_grey1", grey8, 8'h80); chk("w8_wrap1", wrap8, 0);
    tick(); chk("w8_bin2", bin8, 8'h00); chk("w8_grey2", grey8, 8'h00); chk("w8_wrap2", wrap8, 1);
    tick(); chk("w8_bin3", bin8, 8'h01); chk("w8_grey3", grey8, 8'h01); chk("w8_wrap3", wrap8, 0);
    en = 0; cv = 1; cm = 1; ci = 8'h80;
    tick(); chk("w8_g2b", co8, 8'hFF);
    cv = 0;
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = 1'($urandom_range(0, 3) != 0);
      up   = 1'($urandom_range(0, 1));
      lb   = 8'($urandom);
      cv   = 1'($urandom_range(0, 1));
      cm   = 1'($urandom_range(0, 1));
      ci   = 8'($urandom);
      if (i % 97 == 0) lb = 8'hFF;
      tick();
    end
    rst = 0; en = 0; load = 0; cv = 0;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
